// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: fixed-latency word array access with a
// pipeline stall, a registered load result and a sticky misalignment flag.
module dmem_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        done,
    output logic        misaligned
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_cnt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_idx;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic                r_mis;
    logic [31:0]         r_mem [2**ADDR_W];

    logic                w_start;
    logic                w_bad;
    logic                w_fire;
    logic                w_unused;

    assign w_start  = (r_state == S_IDLE) && req && (addr[1:0] == 2'b00);
    assign w_bad    = (r_state == S_IDLE) && req && (addr[1:0] != 2'b00);
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == 4'd0);
    // Address bits above the word index are ignored so accesses wrap.
    assign w_unused = &{1'b0, addr[31:ADDR_W+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_next = S_WAIT;
            S_WAIT:  if (r_cnt == 4'd0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        case (r_state)
            S_IDLE:  stall = w_start;
            S_WAIT:  stall = 1'b1;
            S_DONE:  done  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_idx   <= '0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
            r_mis   <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt   <= 4'(LATENCY - 1);
                r_we    <= we;
                r_idx   <= addr[ADDR_W+1:2];
                r_wdata <= wdata;
            end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_bad) r_mis <= 1'b1;
            if (w_fire && !r_we) r_rdata <= r_mem[r_idx];
        end
    end

    // Array is not reset; a reset coinciding with the final edge suppresses the write.
    always_ff @(posedge clk) begin
        if (w_fire && r_we && !reset) r_mem[r_idx] <= r_wdata;
    end

    assign rdata      = r_rdata;
    assign misaligned = r_mis;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort
// sequence and randomized traffic against a word-array reference model.
module tb_dmem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 2;
    localparam int WORDS   = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        done;
    logic        misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [int];
    logic [31:0] m_rdata;
    logic        m_mis;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        bit          exp_mis;
    } vec_t;

    vec_t vecs [7];

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr),
        .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
        .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % WORDS);
    endfunction

    // One memory instruction starting in the next cycle; req is left high
    // through DONE, as the pipeline would hold it.
    task automatic do_op(input bit w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        #1;
        if (a[1:0] != 2'b00) begin
            chk("mis_stall", {31'd0, stall}, 32'd0);
            m_mis = 1'b1;
            @(negedge clk);
            chk("mis_flag", {31'd0, misaligned}, 32'd1);
            chk("mis_nodone", {31'd0, done}, 32'd0);
            chk("mis_stall2", {31'd0, stall}, 32'd0);
        end else begin
            chk("t0_stall", {31'd0, stall}, 32'd1);
            chk("t0_done", {31'd0, done}, 32'd0);
            for (int k = 1; k <= LATENCY; k++) begin
                @(negedge clk);
                chk("wait_stall", {31'd0, stall}, 32'd1);
                chk("wait_done", {31'd0, done}, 32'd0);
            end
            if (w) m_mem[widx(a)] = d;
            else   m_rdata = m_mem.exists(widx(a)) ? m_mem[widx(a)] : 32'hx;
            @(negedge clk);
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("done_stall", {31'd0, stall}, 32'd0);
            if (!$isunknown(m_rdata)) chk("rdata", rdata, m_rdata);
            chk("mis_hold", {31'd0, misaligned}, {31'd0, m_mis});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("idle_stall", {31'd0, stall}, 32'd0);
        chk("idle_done", {31'd0, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          r;

        vecs[0] = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
        vecs[1] = '{1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0};
        vecs[2] = '{1'b1, 32'h0000_0000, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0};
        vecs[3] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0001, 1'b0};
        vecs[4] = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_0001, 1'b1};
        vecs[5] = '{1'b1, 32'h0000_1000, 32'h0000_00AA, 32'h0000_0001, 1'b1};
        vecs[6] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_00AA, 1'b1};

        reset = 1'b1; req = 1'b0; we = 1'b0; addr = 32'd0; wdata = 32'd0;
        m_rdata = 32'd0; m_mis = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;
        idle();

        // Back-to-back instructions, each issued the cycle after the previous DONE.
        for (int i = 0; i < 7; i++) begin
            do_op(vecs[i].we, vecs[i].addr, vecs[i].wdata);
            chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_mis", i), {31'd0, misaligned}, {31'd0, vecs[i].exp_mis});
        end
        idle();
        idle();

        // Reset in the middle of a store's WAIT aborts the write.
        do_op(1'b1, 32'h20, 32'h11);
        idle();
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55;
        @(negedge clk);
        chk("abort_inwait", {31'd0, stall}, 32'd1);
        reset = 1'b1; req = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_mis", {31'd0, misaligned}, 32'd0);
        m_rdata = 32'd0; m_mis = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) idle();
        do_op(1'b0, 32'h20, 32'h0);
        chk("abort_old_value", rdata, 32'h11);
        idle();

        // Randomized traffic over 16 words with random wrapped upper bits.
        for (int i = 0; i < 16; i++) do_op(1'b1, 32'(i * 4), $urandom);
        for (int n = 0; n < 150; n++) begin
            r = $urandom_range(0, 9);
            a = $urandom;
            if (r == 0) idle();
            else if (r == 1) do_op(1'b0, (a & 32'hFFFF_F03C) | 32'($urandom_range(1, 3)), 32'h0);
            else do_op(r[0], (a & 32'hFFFF_F000) | 32'($urandom_range(0, 15) * 4), $urandom);
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
